// File: rtl/qlf_bram_pkg.sv
// Shared helpers for the asymmetric BRAM FIFOs: width arithmetic, ratio
// legality and the lane/narrow-address mapping common to both variants.
package qlf_bram_pkg;

  // Lane 0 occupies the least significant bits of a wide word and is read first.
  localparam int unsigned LANE_FIRST = 0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits++;
    return bits;
  endfunction

  function automatic bit ratio_legal(input int unsigned wide_width,
                                     input int unsigned narrow_width);
    int unsigned ratio;
    if (narrow_width == 0 || (wide_width % narrow_width) != 0) return 1'b0;
    ratio = wide_width / narrow_width;
    return (ratio == 1) || (ratio == 2) || (ratio == 4);
  endfunction

  function automatic int unsigned lane_bits(input int unsigned ratio);
    return clog2(ratio);
  endfunction

  function automatic int unsigned narrow_addr(input int unsigned word,
                                              input int unsigned lane,
                                              input int unsigned ratio);
    return word * ratio + lane;
  endfunction

endpackage

// File: rtl/bram_asymmetric_wider_write_fifo_if.sv
// Producer/consumer bus of the wide-write, narrow-read FIFO.
interface bram_asymmetric_wider_write_fifo_if
  import qlf_bram_pkg::*;
#(
  parameter int unsigned WRITE_DATA_WIDTH = 32,
  parameter int unsigned READ_DATA_WIDTH  = 16,
  parameter int unsigned WRITE_ADDR_WIDTH = 10
);
  localparam int unsigned LEVEL_WIDTH =
    WRITE_ADDR_WIDTH + lane_bits(WRITE_DATA_WIDTH / READ_DATA_WIDTH) + 2;

  logic                        wr_valid;
  logic                        wr_ready;
  logic [WRITE_DATA_WIDTH-1:0] wr_data;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [READ_DATA_WIDTH-1:0]  rd_data;
  logic [LEVEL_WIDTH-1:0]      level;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level
  );

endinterface

// File: rtl/bram_asym_wide_write_ram.sv
// Behavioural asymmetric BRAM: one wide write port, one narrow read port with
// a registered output (1-cycle latency, old data on same-edge write).
module bram_asym_wide_write_ram
  import qlf_bram_pkg::*;
#(
  parameter int unsigned WRITE_DATA_WIDTH = 32,
  parameter int unsigned READ_DATA_WIDTH  = 16,
  parameter int unsigned WRITE_ADDR_WIDTH = 10,
  localparam int unsigned RATIO           = WRITE_DATA_WIDTH / READ_DATA_WIDTH,
  localparam int unsigned LANE_BITS       = lane_bits(RATIO),
  localparam int unsigned READ_ADDR_WIDTH = WRITE_ADDR_WIDTH + LANE_BITS
) (
  input  logic                        clk,
  input  logic                        wce,
  input  logic [WRITE_ADDR_WIDTH-1:0] wa,
  input  logic [WRITE_DATA_WIDTH-1:0] wd,
  input  logic                        rce,
  input  logic [READ_ADDR_WIDTH-1:0]  ra,
  output logic [READ_DATA_WIDTH-1:0]  rq
);
  localparam int unsigned LANE_W = (LANE_BITS == 0) ? 1 : LANE_BITS;

  logic [WRITE_DATA_WIDTH-1:0] mem [2**WRITE_ADDR_WIDTH];
  logic [WRITE_ADDR_WIDTH-1:0] rword;
  logic [LANE_W-1:0]           rlane;

  // Narrow address = RATIO*word + lane, so the low bits select the lane.
  assign rword = WRITE_ADDR_WIDTH'(ra >> LANE_BITS);
  assign rlane = LANE_W'(ra & READ_ADDR_WIDTH'(RATIO - 1));

  // NOTE: the array and its output register have no reset so the tools can
  // map them onto the BRAM primitive; nothing downstream trusts rq unless a
  // fetch was issued the cycle before.
  always_ff @(posedge clk) begin
    if (wce) mem[wa] <= wd;
    if (rce) rq <= mem[rword][rlane * READ_DATA_WIDTH +: READ_DATA_WIDTH];
  end

endmodule

// File: rtl/bram_asymmetric_wider_write_fifo.sv
// Wide-write, narrow-read FIFO: asymmetric BRAM storage drained through a
// 2-entry output stage (head + skid) so a stalled reader never loses data.
module bram_asymmetric_wider_write_fifo
  import qlf_bram_pkg::*;
#(
  parameter int unsigned WRITE_DATA_WIDTH = 32,
  parameter int unsigned READ_DATA_WIDTH  = 16,
  parameter int unsigned WRITE_ADDR_WIDTH = 10
) (
  input logic                              clk,
  input logic                              rst_n,
  bram_asymmetric_wider_write_fifo_if.slave bus
);
  localparam int unsigned RATIO           = WRITE_DATA_WIDTH / READ_DATA_WIDTH;
  localparam int unsigned READ_ADDR_WIDTH = WRITE_ADDR_WIDTH + lane_bits(RATIO);
  localparam int unsigned DEPTH_N         = 2 ** READ_ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH       = READ_ADDR_WIDTH + 2;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t RATIO_C  = cnt_t'(RATIO);
  localparam cnt_t WR_LIMIT = cnt_t'(DEPTH_N - RATIO);

  if (!ratio_legal(WRITE_DATA_WIDTH, READ_DATA_WIDTH)) begin : g_bad_ratio
    $error("WRITE_DATA_WIDTH/READ_DATA_WIDTH must be 1, 2 or 4");
  end

  logic [WRITE_ADDR_WIDTH-1:0] wptr;
  logic [READ_ADDR_WIDTH-1:0]  rptr;
  cnt_t                        scnt, scnt_n;
  cnt_t                        level, level_n;
  logic                        inflight;
  logic [1:0]                  ostage_cnt, ostage_cnt_n, kept;
  logic [READ_DATA_WIDTH-1:0]  head, head_n, skid, skid_n;
  logic [READ_DATA_WIDTH-1:0]  rq;
  logic [2:0]                  claim;
  logic                        wr_acc, pop, issue;

  // wr_ready depends only on registered occupancy; free space is always a
  // whole aligned wide slot at wptr because narrow reads retire in order.
  assign bus.wr_ready = rst_n & (scnt <= WR_LIMIT);
  assign bus.rd_valid = (ostage_cnt != 2'd0);
  assign bus.rd_data  = head;
  assign bus.level    = level;

  assign wr_acc = bus.wr_valid & bus.wr_ready;
  assign pop    = bus.rd_valid & bus.rd_ready;

  // A fetch may be issued if its result will still find a free output slot.
  assign claim = {1'b0, ostage_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (scnt != '0) && (claim < 3'd2);

  bram_asym_wide_write_ram #(
    .WRITE_DATA_WIDTH (WRITE_DATA_WIDTH),
    .READ_DATA_WIDTH  (READ_DATA_WIDTH),
    .WRITE_ADDR_WIDTH (WRITE_ADDR_WIDTH)
  ) u_ram (
    .clk (clk),
    .wce (wr_acc),
    .wa  (wptr),
    .wd  (bus.wr_data),
    .rce (issue),
    .ra  (rptr),
    .rq  (rq)
  );

  // NOTE: every variable gets its hold value first so no path through this
  // block can leave one unassigned and infer a latch.
  always_comb begin
    head_n = head;
    skid_n = skid;
    kept   = ostage_cnt - {1'b0, pop};
    if (pop) head_n = skid;
    if (inflight) begin
      if (kept == 2'd0) head_n = rq;
      else              skid_n = rq;
    end
    ostage_cnt_n = kept + {1'b0, inflight};
    scnt_n       = scnt + (wr_acc ? RATIO_C : '0) - cnt_t'(issue);
    level_n      = scnt_n + cnt_t'(issue) + cnt_t'(ostage_cnt_n);
  end

  // NOTE: state updates use <= so every register samples pre-edge values,
  // independent of the order of statements in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      scnt       <= '0;
      inflight   <= 1'b0;
      ostage_cnt <= 2'd0;
      head       <= '0;
      skid       <= '0;
      level      <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (issue)  rptr <= rptr + 1'b1;
      scnt       <= scnt_n;
      inflight   <= issue;
      ostage_cnt <= ostage_cnt_n;
      head       <= head_n;
      skid       <= skid_n;
      level      <= level_n;
    end
  end

endmodule

// File: tb/tb_bram_asymmetric_wider_write_fifo.sv
// Bench for the wide-write FIFO: queue model of the narrow word stream checked
// every cycle, plus directed latency, capacity and reset scenarios.
`timescale 1ns/1ps
module tb_bram_asymmetric_wider_write_fifo;
  localparam int unsigned WDW     = 32;
  localparam int unsigned RDW     = 16;
  localparam int unsigned WAW     = 10;
  localparam int unsigned RATIO   = WDW / RDW;
  localparam int unsigned DEPTH_N = (2 ** WAW) * RATIO;
  localparam int unsigned CAP     = DEPTH_N + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  bram_asymmetric_wider_write_fifo_if #(
    .WRITE_DATA_WIDTH (WDW),
    .READ_DATA_WIDTH  (RDW),
    .WRITE_ADDR_WIDTH (WAW)
  ) bus ();

  bram_asymmetric_wider_write_fifo #(
    .WRITE_DATA_WIDTH (WDW),
    .READ_DATA_WIDTH  (RDW),
    .WRITE_ADDR_WIDTH (WAW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WDW-1:0] pat(input int unsigned a);
    logic [WDW-1:0] av;
    av = WDW'(a);
    return av | (av << 20) | 32'h0005_5000;
  endfunction

  // Model: the FIFO holds exactly the narrow words accepted and not yet popped,
  // lane 0 of each wide word first.
  logic [RDW-1:0] mq [$];
  logic           hold;
  logic [RDW-1:0] hold_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_level", 64'(bus.level), 64'd0);
      check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
      mq.delete();
      hold = 1'b0;
    end else begin
      check("level_vs_model", 64'(bus.level), 64'(mq.size()));
      check("level_cap", 64'(bus.level <= CAP), 64'd1);
      if (hold) begin
        check("hold_valid", 64'(bus.rd_valid), 64'd1);
        check("hold_data", 64'(bus.rd_data), 64'(hold_data));
      end
      if (bus.rd_valid && mq.size() == 0)
        check("valid_while_empty", 64'(bus.rd_valid), 64'd0);
      if (bus.rd_valid && bus.rd_ready && mq.size() != 0) begin
        check("rd_data_order", 64'(bus.rd_data), 64'(mq[0]));
        void'(mq.pop_front());
        n_pops++;
      end
      hold      = bus.rd_valid & ~bus.rd_ready;
      hold_data = bus.rd_data;
      if (bus.wr_valid && bus.wr_ready)
        for (int k = 0; k < int'(RATIO); k++) mq.push_back(bus.wr_data[k*RDW +: RDW]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < budget && bus.level != 0; i++) step();
    check(name, 64'(bus.level), 64'd0);
  endtask

  initial begin
    int unsigned acc;
    int unsigned sent;
    int          base;
    logic        ready;

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (3) step();
    check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("reset_level", 64'(bus.level), 64'd0);
    check("reset_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("reset_rd_data", 64'(bus.rd_data), 64'd0);
    rst_n = 1'b1;
    step();
    check("release_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("release_rd_valid", 64'(bus.rd_valid), 64'd0);

    // Lane order and two-edge latency.
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h1234_5678;
    step();
    bus.wr_valid = 1'b0;
    check("lat_e0_valid", 64'(bus.rd_valid), 64'd0);
    check("lat_e0_level", 64'(bus.level), 64'd2);
    step();
    check("lat_e1_valid", 64'(bus.rd_valid), 64'd0);
    step();
    check("lat_e2_valid", 64'(bus.rd_valid), 64'd1);
    check("lane0", 64'(bus.rd_data), 64'h5678);
    step();
    check("lane1_valid", 64'(bus.rd_valid), 64'd1);
    check("lane1", 64'(bus.rd_data), 64'h1234);
    check("lane1_level", 64'(bus.level), 64'd1);
    step();
    check("lanes_done_valid", 64'(bus.rd_valid), 64'd0);
    check("lanes_done_level", 64'(bus.level), 64'd0);

    // Fill with a stalled reader.
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 1100; i++) begin
      ready       = bus.wr_ready;
      bus.wr_data = pat(acc);
      step();
      if (ready) acc++;
    end
    bus.wr_valid = 1'b0;
    check("fill_accepted", 64'(acc), 64'd1025);
    check("fill_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("fill_level", 64'(bus.level), 64'd2050);
    check("fill_head", 64'(bus.rd_data), 64'h5000);

    // Two pops reopen exactly one wide slot.
    bus.rd_ready = 1'b1;
    step();
    check("pop1_wr_ready", 64'(bus.wr_ready), 64'd0);
    step();
    bus.rd_ready = 1'b0;
    check("pop2_wr_ready", 64'(bus.wr_ready), 64'd1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = pat(acc);
    step();
    bus.wr_valid = 1'b0;
    check("refill_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("refill_level", 64'(bus.level), 64'd2050);
    drain("fill_drain_level", 3000);
    check("fill_drain_valid", 64'(bus.rd_valid), 64'd0);

    // Random stream across pointer wrap.
    base = n_pops;
    sent = 0;
    for (int cyc = 0; cyc < 40000 && sent < 3000; cyc++) begin
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.rd_ready = ($urandom_range(0, 3) != 0);
      bus.wr_data  = $urandom();
      ready        = bus.wr_ready;
      step();
      if (bus.wr_valid && ready) sent++;
    end
    bus.wr_valid = 1'b0;
    check("stream_sent", 64'(sent), 64'd3000);
    drain("stream_drain_level", 5000);
    check("stream_pops", 64'(n_pops - base), 64'd6000);

    // Reset in the middle of traffic.
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 200 && bus.level < 100; i++) begin
      bus.wr_data = pat(i);
      step();
    end
    bus.wr_valid = 1'b0;
    check("midrst_pre_level", 64'(bus.level), 64'd100);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("midrst_level", 64'(bus.level), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hCAFE_BEEF;
    step();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.rd_valid; i++) step();
    check("post_rst_valid", 64'(bus.rd_valid), 64'd1);
    check("post_rst_lane0", 64'(bus.rd_data), 64'hBEEF);
    drain("post_rst_drain_level", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
